// File: rtl/packet_reg_bridge.sv
// Packet-to-register bridge: command packets on the Rx stream write or read a
// register bus; reads answer with a header byte plus data on the Tx stream.
// Define WRITE_ACK_EN to add a one-byte acknowledge (TX_ACK) after each write packet.
package packet_reg_bridge_pkg;
  typedef struct packed {
    logic [7:0] Source;
    logic [7:0] Destination;
    logic [7:0] Length;
    logic       SoP;
    logic       EoP;
    logic       Valid;
    logic [7:0] Data;
  } UART_PACKET;
endpackage

module packet_reg_bridge
  import packet_reg_bridge_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    ipClk,
  input  logic                    ipReset,
  input  UART_PACKET              ipRxStream,
  output UART_PACKET              opTxStream,
  input  logic                    ipTxReady,
  output logic [ADDR_WIDTH-1:0]   opAddress,
  output logic [8*DATA_BYTES-1:0] opWrData,
  output logic                    opWrEnable,
  input  logic [8*DATA_BYTES-1:0] ipRdData
);
  localparam int DW  = 8*DATA_BYTES;
  localparam int BCW = $clog2(DATA_BYTES+1);
  localparam logic [BCW-1:0] LAST = BCW'(DATA_BYTES-1);

  typedef enum logic [2:0] {
    IDLE, WRITE, RD_ISSUE, RD_WAIT, TX_HEAD, TX_DATA
`ifdef WRITE_ACK_EN
    , TX_ACK
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;   // drives opAddress
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;     // next write address / read base address
  logic [7:0]            src_q, src_d, dst_q, dst_d;
  logic [DW-1:0]         shift_q, shift_d, wr_data_q, wr_data_d;
  logic [BCW-1:0]        bcnt_q, bcnt_d;
  logic [7:0]            cnt_q, cnt_d;     // read words left; 0 = count byte still pending
  logic                  first_q, first_d, wr_en_q, wr_en_d;
`ifdef WRITE_ACK_EN
  logic [7:0]            wcnt_q, wcnt_d;
`endif
  logic [DW-1:0]         rx_shift;
  logic [7:0]            resp_len;
  logic                  rx_sop, tx_fire;

  assign rx_shift   = DW'({ipRxStream.Data, shift_q} >> 8);
  assign resp_len   = 8'(32'(cnt_q) * DATA_BYTES + 1);
  assign rx_sop     = ipRxStream.Valid & ipRxStream.SoP;
  assign tx_fire    = opTxStream.Valid & ipTxReady;
  assign opAddress  = addr_q;
  assign opWrData   = wr_data_q;
  assign opWrEnable = wr_en_q;

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      addr_q <= '0; ptr_q <= '0; src_q <= '0; dst_q <= '0;
      shift_q <= '0; wr_data_q <= '0; bcnt_q <= '0; cnt_q <= '0;
      first_q <= 1'b0; wr_en_q <= 1'b0;
`ifdef WRITE_ACK_EN
      wcnt_q <= '0;
`endif
    end else begin
      addr_q <= addr_d; ptr_q <= ptr_d; src_q <= src_d; dst_q <= dst_d;
      shift_q <= shift_d; wr_data_q <= wr_data_d; bcnt_q <= bcnt_d; cnt_q <= cnt_d;
      first_q <= first_d; wr_en_q <= wr_en_d;
`ifdef WRITE_ACK_EN
      wcnt_q <= wcnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q; addr_d = addr_q; ptr_d = ptr_q; src_d = src_q; dst_d = dst_q;
    shift_d = shift_q; wr_data_d = wr_data_q; bcnt_d = bcnt_q; cnt_d = cnt_q;
    first_d = first_q; wr_en_d = 1'b0;
`ifdef WRITE_ACK_EN
    wcnt_d = wcnt_q;
`endif
    case (state_q)
      WRITE: if (ipRxStream.Valid && !ipRxStream.SoP) begin
        shift_d = rx_shift;
        if (bcnt_q == LAST) begin
          wr_data_d = rx_shift;
          wr_en_d   = 1'b1;
          addr_d    = ptr_q;
          ptr_d     = ptr_q + ADDR_WIDTH'(1);
          bcnt_d    = '0;
`ifdef WRITE_ACK_EN
          wcnt_d    = wcnt_q + 8'd1;
`endif
        end else begin
          bcnt_d = bcnt_q + BCW'(1);
        end
        if (ipRxStream.EoP) begin
`ifdef WRITE_ACK_EN
          state_d = TX_ACK;
`else
          state_d = IDLE;
`endif
        end
      end
      RD_ISSUE: begin
        // A multi-byte read carries its word count in the second byte
        if (cnt_q == 8'd0) begin
          if (ipRxStream.Valid) cnt_d = (ipRxStream.Data == 8'd0) ? 8'd1 : ipRxStream.Data;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        shift_d = ipRdData;
        bcnt_d  = '0;
        state_d = first_q ? TX_HEAD : TX_DATA;
      end
      TX_HEAD: if (tx_fire) begin
        first_d = 1'b0;
        state_d = TX_DATA;
      end
      TX_DATA: if (tx_fire) begin
        shift_d = shift_q >> 8;
        if (bcnt_q == LAST) begin
          bcnt_d  = '0;
          addr_d  = addr_q + ADDR_WIDTH'(1);
          cnt_d   = cnt_q - 8'd1;
          state_d = (cnt_q == 8'd1) ? IDLE : RD_ISSUE;
        end else begin
          bcnt_d = bcnt_q + BCW'(1);
        end
      end
`ifdef WRITE_ACK_EN
      TX_ACK: if (tx_fire) state_d = IDLE;
`endif
      default: ;
    endcase
    // A start of packet in IDLE or WRITE begins a fresh command
    if (rx_sop && (state_q == IDLE || state_q == WRITE)) begin
      src_d   = ipRxStream.Source;
      dst_d   = ipRxStream.Destination;
      addr_d  = ipRxStream.Data[ADDR_WIDTH-1:0];
      ptr_d   = ipRxStream.Data[ADDR_WIDTH-1:0];
      shift_d = '0;
      bcnt_d  = '0;
      first_d = 1'b1;
      cnt_d   = (ipRxStream.Length == 8'd1) ? 8'd1 : 8'd0;
`ifdef WRITE_ACK_EN
      wcnt_d  = '0;
`endif
      case (ipRxStream.Destination)
        8'd1:    state_d = WRITE;
        8'd0:    state_d = RD_ISSUE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    opTxStream = '0;
    case (state_q)
      TX_HEAD: begin
        opTxStream.Valid       = 1'b1;
        opTxStream.SoP         = 1'b1;
        opTxStream.Source      = dst_q;
        opTxStream.Destination = src_q;
        opTxStream.Length      = resp_len;
        opTxStream.Data        = 8'(ptr_q);
      end
      TX_DATA: begin
        opTxStream.Valid       = 1'b1;
        opTxStream.EoP         = (cnt_q == 8'd1) && (bcnt_q == LAST);
        opTxStream.Source      = dst_q;
        opTxStream.Destination = src_q;
        opTxStream.Data        = shift_q[7:0];
      end
`ifdef WRITE_ACK_EN
      TX_ACK: begin
        opTxStream.Valid       = 1'b1;
        opTxStream.SoP         = 1'b1;
        opTxStream.EoP         = 1'b1;
        opTxStream.Source      = dst_q;
        opTxStream.Destination = src_q;
        opTxStream.Length      = 8'd1;
        opTxStream.Data        = wcnt_q;
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_packet_reg_bridge.sv
// Scoreboard bench for packet_reg_bridge: stimulus pushes expected strobes and Tx
// bytes into queues; a monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_packet_reg_bridge;
  import packet_reg_bridge_pkg::*;
  localparam int DB = 4;
  localparam int AW = 8;
`ifdef WRITE_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ready = 1'b1;
  UART_PACKET rx, tx;
  logic [AW-1:0]   addr;
  logic [8*DB-1:0] wr_data, rd_data;
  logic            wr_en;
  logic [31:0]     mem [256];
  int  total = 0, bad = 0, txn_cnt = 0;
  bit  stall_mode = 1'b0;
  wr_t        wr_q [$];
  UART_PACKET tx_q [$];
  logic [7:0] bq [$];

  packet_reg_bridge #(.DATA_BYTES(DB), .ADDR_WIDTH(AW)) dut (
    .ipClk(clk), .ipReset(rst_n), .ipRxStream(rx), .opTxStream(tx),
    .ipTxReady(ready), .opAddress(addr), .opWrData(wr_data),
    .opWrEnable(wr_en), .ipRdData(rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= mem[addr];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic exp_tx(input logic [7:0] src, dst, len, input bit sop, eop, input logic [7:0] data);
    UART_PACKET p;
    p = '0;
    p.Valid = 1'b1; p.Source = src; p.Destination = dst; p.Length = len;
    p.SoP = sop; p.EoP = eop; p.Data = data;
    tx_q.push_back(p);
  endtask

  task automatic exp_ack(input logic [7:0] src, input logic [7:0] n);
    if (ACK_EN) exp_tx(8'd1, src, 8'd1, 1'b1, 1'b1, n);
  endtask

  task automatic exp_read(input logic [7:0] src, base, input int n, input logic [31:0] w0, w1);
    logic [31:0] wd;
    exp_tx(8'd0, src, 8'(1 + 4*n), 1'b1, 1'b0, base);
    for (int w = 0; w < n; w++) begin
      wd = (w == 0) ? w0 : w1;
      for (int b = 0; b < 4; b++)
        exp_tx(8'd0, src, 8'd0, 1'b0, (w == n-1) && (b == 3), wd[8*b +: 8]);
    end
  endtask

  task automatic send_pkt(input logic [7:0] src, dst, input bit with_eop);
    int n;
    n = bq.size();
    for (int i = 0; i < n; i++) begin
      rx = '0;
      rx.Valid = 1'b1; rx.Source = src; rx.Destination = dst; rx.Length = 8'(n);
      rx.SoP = (i == 0); rx.EoP = with_eop && (i == n-1); rx.Data = bq[i];
      @(posedge clk); #1;
    end
    rx = '0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((wr_q.size() != 0 || tx_q.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (n >= 500) begin
      bad++;
      $display("FAIL %s drain: pending wr=%0d tx=%0d, expected 0", name, wr_q.size(), tx_q.size());
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Ready generator: in stall mode each presented byte waits 5 cycles.
  initial begin
    int scnt;
    scnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!stall_mode) ready = 1'b1;
      else if (ready) begin ready = 1'b0; scnt = 0; end
      else if (tx.Valid) begin
        scnt++;
        if (scnt == 5) ready = 1'b1;
      end
    end
  end

  // Monitor
  initial begin
    UART_PACKET e, prev;
    wr_t w;
    bit prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (wr_en) begin
          if (wr_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_wr: addr=%0h data=%0h, expected no strobe", addr, wr_data);
          end else begin
            w = wr_q.pop_front();
            $display("wr strobe addr=%0h data=%0h", addr, wr_data);
            check("wr_addr", 64'(addr), 64'(w.addr));
            check("wr_data", 64'(wr_data), 64'(w.data));
          end
        end
        if (prev_stall) begin
          check("hold_valid", 64'(tx.Valid), 64'(1'b1));
          check("hold_data", 64'(tx.Data), 64'(prev.Data));
        end
        if (tx.Valid && ready) begin
          txn_cnt++;
          if (tx_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_tx: data=%0h sop=%0b eop=%0b, expected none", tx.Data, tx.SoP, tx.EoP);
          end else begin
            e = tx_q.pop_front();
            $display("tx byte data=%0h sop=%0b eop=%0b len=%0d", tx.Data, tx.SoP, tx.EoP, tx.Length);
            check("tx_data", 64'(tx.Data), 64'(e.Data));
            check("tx_sop", 64'(tx.SoP), 64'(e.SoP));
            check("tx_eop", 64'(tx.EoP), 64'(e.EoP));
            if (e.SoP) begin
              check("tx_src", 64'(tx.Source), 64'(e.Source));
              check("tx_dst", 64'(tx.Destination), 64'(e.Destination));
              check("tx_len", 64'(tx.Length), 64'(e.Length));
            end
          end
        end
        prev_stall = tx.Valid && !ready;
        prev = tx;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    rx = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | i;
    mem[8'hFF] = 32'h0000_0001;
    mem[8'h00] = 32'h0000_0002;
    repeat (3) @(posedge clk); #1;
    check("rst_tx", 64'(tx), 64'(0));
    check("rst_addr", 64'(addr), 64'(0));
    check("rst_wrdata", 64'(wr_data), 64'(0));
    check("rst_wren", 64'(wr_en), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-word write
    wr_q.push_back('{8'h10, 32'h1122_3344});
    exp_ack(8'd5, 8'd1);
    bq = '{8'h10, 8'h44, 8'h33, 8'h22, 8'h11};
    send_pkt(8'd5, 8'd1, 1'b1);
    wait_drain("write1");

    // Two-word read across the address wrap
    exp_read(8'd5, 8'hFF, 2, 32'h1, 32'h2);
    bq = '{8'hFF, 8'h02};
    send_pkt(8'd5, 8'd0, 1'b1);
    wait_drain("read2");

    // Same read with Tx back-pressure
    stall_mode = 1'b1;
    exp_read(8'd7, 8'hFF, 2, 32'h1, 32'h2);
    bq = '{8'hFF, 8'h02};
    send_pkt(8'd7, 8'd0, 1'b1);
    wait_drain("read_stall");
    stall_mode = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Partial word then a two-word write wrapping the address
    exp_ack(8'd5, 8'd0);
    bq = '{8'h20, 8'hAA, 8'hBB, 8'hCC};
    send_pkt(8'd5, 8'd1, 1'b1);
    wait_drain("partial");
    wr_q.push_back('{8'hFF, 32'h0403_0201});
    wr_q.push_back('{8'h00, 32'h0807_0605});
    exp_ack(8'd5, 8'd2);
    bq = '{8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_pkt(8'd5, 8'd1, 1'b1);
    wait_drain("write2");

    // Unknown destination is ignored
    bq = '{8'h70, 8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt(8'd5, 8'd2, 1'b1);
    wait_drain("bad_dest");

    // SoP in the middle of a write restarts the command
    wr_q.push_back('{8'h50, 32'hDEAD_BEEF});
    exp_ack(8'd6, 8'd1);
    bq = '{8'h40, 8'h01, 8'h02};
    send_pkt(8'd6, 8'd1, 1'b0);
    bq = '{8'h50, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_pkt(8'd6, 8'd1, 1'b1);
    wait_drain("abort");

    // Length 1 read, and count byte 0 treated as one word
    exp_read(8'd3, 8'h00, 1, 32'h2, 32'h0);
    bq = '{8'h00};
    send_pkt(8'd3, 8'd0, 1'b1);
    wait_drain("read_len1");
    exp_read(8'd3, 8'h05, 1, 32'hC0DE_0005, 32'h0);
    bq = '{8'h05, 8'h00};
    send_pkt(8'd3, 8'd0, 1'b1);
    wait_drain("read_cnt0");

    // Reset while the second data byte is presented
    base = txn_cnt;
    exp_read(8'd5, 8'hFF, 2, 32'h1, 32'h2);
    bq = '{8'hFF, 8'h02};
    send_pkt(8'd5, 8'd0, 1'b1);
    n = 0;
    while (txn_cnt < base + 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("reach_byte2", 64'(n < 200), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", 64'(tx), 64'(0));
    check("midrst_addr", 64'(addr), 64'(0));
    check("midrst_wrdata", 64'(wr_data), 64'(0));
    check("midrst_wren", 64'(wr_en), 64'(0));
    tx_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("no_tx_after_rst", 64'(txn_cnt), 64'(base + 2));

    // Normal operation resumes after reset
    wr_q.push_back('{8'h60, 32'hCAFE_F00D});
    exp_ack(8'd9, 8'd1);
    bq = '{8'h60, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    send_pkt(8'd9, 8'd1, 1'b1);
    wait_drain("write_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/packet_reg_bridge.md
PACKET_REG_BRIDGE -- requirements
Module: packet_reg_bridge

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 4, bytes per register word (1..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, register address width (1..8).
REQ-003 SHALL have port ipClk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port ipReset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ipRxStream, input, UART_PACKET (Source, Destination, Length, SoP, EoP, Valid, Data[7:0]), command bytes.
REQ-006 SHALL have port opTxStream, output, UART_PACKET, response bytes.
REQ-007 SHALL have port ipTxReady, input, 1; a Tx byte transfers on the clock where opTxStream.Valid and ipTxReady are both high.
REQ-008 SHALL have port opAddress, output, ADDR_WIDTH, register address.
REQ-009 SHALL have port opWrData, output, 8*DATA_BYTES, write data.
REQ-010 SHALL have port opWrEnable, output, 1, single-cycle write strobe.
REQ-011 SHALL have port ipRdData, input, 8*DATA_BYTES; valid one clock after opAddress changes.

Function
REQ-012 SHALL implement states IDLE, WRITE, RD_ISSUE, RD_WAIT, TX_HEAD, TX_DATA and, when configured, TX_ACK.
REQ-013 IDLE: on Rx Valid&SoP, latch Data[ADDR_WIDTH-1:0] as base address, Source, Destination, Length; Destination 1 -> WRITE, 0 -> RD_ISSUE, other -> stay IDLE.
REQ-014 WRITE: each Valid byte shifts in LSB-first; on the DATA_BYTES-th byte, same edge drives opWrData, opAddress = current address, opWrEnable=1 for exactly one clock, then address += 1.
REQ-015 Write burst: word count = (Length-1)/DATA_BYTES; return to IDLE after the EoP byte.
REQ-016 EoP mid-word SHALL discard the partial word with no strobe; SoP in WRITE SHALL abort and restart as a new command in that cycle.
REQ-017 Read word count: 1 if Length==1, else the second Rx byte (0 treated as 1).
REQ-018 RD_ISSUE drives opAddress; RD_WAIT captures ipRdData one clock later into the Tx shift register.
REQ-019 TX_HEAD: sends one byte, Data=base address, SoP=1, Source/Destination = latched Destination/Source, Length = 1 + count*DATA_BYTES (mod 256).
REQ-020 TX_DATA: sends word LSB-first, one byte per accepted transfer; after DATA_BYTES bytes, address += 1 and return to RD_ISSUE until count exhausted; last byte EoP=1, then IDLE.
REQ-021 Valid and Data SHALL hold stable while ipTxReady is low.
REQ-022 Rx bytes arriving while in RD_ISSUE/RD_WAIT/TX_*/TX_ACK SHALL be dropped.
REQ-023 Address increment SHALL wrap modulo 2^ADDR_WIDTH.

Reset
REQ-024 On ipReset low: state IDLE, opTxStream all fields 0, opAddress 0, opWrData 0, opWrEnable 0, counters 0, immediately and asynchronously.
REQ-025 Reset mid-packet SHALL abandon the packet; no further strobe or Tx byte.

Configuration
REQ-026 With WRITE_ACK_EN defined, after a write packet's EoP SHALL enter TX_ACK and send one byte: SoP=EoP=1, Length=1, Data = number of words written, swapped Source/Destination.
REQ-027 Without WRITE_ACK_EN, writes SHALL produce no Tx traffic and TX_ACK SHALL not exist.

Verification
REQ-028 Write Dest=1, Length=5, bytes 10,44,33,22,11 -> one opWrEnable, opAddress 0x10, opWrData 0x11223344.
REQ-029 Read Dest=0, Length=2, bytes 0xFF,2, model returns A0 -> 0x01; B0 -> 0x02 -> Tx 9 bytes FF,01,00,00,00,02,00,00,00; Length 9; address wraps to 0x00.
REQ-030 Read with ipTxReady low 5 cycles per byte -> Tx Data/Valid unchanged during stalls, byte sequence identical.
REQ-031 Write of 3 data bytes then EoP -> no opWrEnable; next packet executes normally.
REQ-032 ipReset low during TX_DATA byte 2 -> all outputs 0 within the reset; no further Tx after release.
REQ-033 WRITE_ACK_EN defined, 2-word write -> single ack byte, Data=2, SoP=EoP=1.
